// File: rtl/dmem_pkg.sv
// Shared encodings for the handshaked data memory: access sizes, FSM states
// and the latency-counter width helper.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // A single-cycle memory never counts, but still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response bundle between the MEM stage and the data memory.
interface data_mem_hs_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_i;
    logic              we_i;
    logic [1:0]        size_i;
    logic              unsigned_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic              busy_o;
    logic              ack_o;
    logic [31:0]       rdata_o;
    logic              err_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        input  busy_o, ack_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        output busy_o, ack_o, rdata_o, err_o
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges store data into the old word and extracts and
// extends load data from it, little-endian.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] store_word,
    output logic [31:0] load_val
);
    logic [3:0]  be;
    logic [31:0] rep;
    logic [31:0] shifted;

    always_comb begin
        be  = '0;
        rep = wdata;
        case (size)
            SZ_BYTE: begin
                be  = 4'b0001 << lane;
                rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be  = lane[1] ? 4'b1100 : 4'b0011;
                rep = {2{wdata[15:0]}};
            end
            SZ_WORD: be = '1;
            default: be = '0;
        endcase
        store_word = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) store_word[i*8 +: 8] = rep[i*8 +: 8];
        end
    end

    always_comb begin
        shifted = old_word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: load_val = is_unsigned ? {24'h0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_val = is_unsigned ? {16'h0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            SZ_WORD: load_val = old_word;
            default: load_val = '0;
        endcase
    end
endmodule

// File: rtl/data_mem_hs.sv
// MEM-stage data memory with req/busy/ack handshake, configurable latency,
// sub-word accesses and fault reporting.
module data_mem_hs
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    data_mem_hs_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = cnt_width(LATENCY);
    localparam int unsigned LAT_M2 = (LATENCY >= 2) ? LATENCY - 2 : 0;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic              lat_we, lat_uns;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic              cur_we, cur_uns;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;

    logic              accept, commit, oob, misalign, fault;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       old_word, store_word, load_val;
    logic [31:0]       rdata_q;
    logic              err_q;

    assign accept = (state == ST_IDLE) && bus.req_i;
    assign commit = (state_nxt == ST_RESP);

    // With LATENCY=1 the commit edge is the accept edge, so the request is
    // taken straight from the bus while idle instead of from the latch.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_we    = bus.we_i;
            cur_uns   = bus.unsigned_i;
            cur_size  = bus.size_i;
            cur_addr  = bus.addr_i;
            cur_wdata = bus.wdata_i;
        end else begin
            cur_we    = lat_we;
            cur_uns   = lat_uns;
            cur_size  = lat_size;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
        end
    end

    assign idx = cur_addr[IDX_W+1:2];

    generate
        if (ADDR_W > IDX_W + 2) begin : g_oob
            assign oob = |cur_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_oob
            assign oob = 1'b0;
        end
    endgenerate

    always_comb begin
        case (cur_size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = cur_addr[0];
            SZ_WORD: misalign = |cur_addr[1:0];
            default: misalign = 1'b1;
        endcase
    end

    assign fault    = oob | misalign;
    assign old_word = mem[idx];

    dmem_lane_align u_align (
        .size       (cur_size),
        .lane       (cur_addr[1:0]),
        .is_unsigned(cur_uns),
        .old_word   (old_word),
        .wdata      (cur_wdata),
        .store_word (store_word),
        .load_val   (load_val)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.req_i) begin
                    if (LATENCY == 1) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_W'(LAT_M2);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) state_nxt = ST_RESP;
                else           cnt_nxt   = cnt - 1'b1;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o = (state != ST_IDLE);
        bus.ack_o  = (state == ST_RESP);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= bus.we_i;
                lat_uns   <= bus.unsigned_i;
                lat_size  <= bus.size_i;
                lat_addr  <= bus.addr_i;
                lat_wdata <= bus.wdata_i;
            end
            if (commit) begin
                err_q   <= fault;
                rdata_q <= (fault || cur_we) ? '0 : load_val;
            end
        end
    end

    // Array contents survive reset; a reset on the commit edge aborts the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit && cur_we && !fault) mem[idx] <= store_word;
    end

    assign bus.rdata_o = rdata_q;
    assign bus.err_o   = err_q;
endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs at latencies 2, 4 and 1 against a byte-array model.
module tb_data_mem_hs;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 256;

    function automatic int unsigned lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_a, we_a, uns_a, busy_a, ack_a, err_a;
    logic [1:0]  size_a  [3];
    logic [31:0] addr_a  [3];
    logic [31:0] wdata_a [3];
    logic [31:0] rdata_a [3];

    int          checks = 0;
    int          passes = 0;
    exp_t        exp_q[$];
    logic [7:0]  ref_mem [3][4*DEPTH];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_hs_if #(.ADDR_W(32)) bus ();
        assign bus.req_i      = req_a[g];
        assign bus.we_i       = we_a[g];
        assign bus.size_i     = size_a[g];
        assign bus.unsigned_i = uns_a[g];
        assign bus.addr_i     = addr_a[g];
        assign bus.wdata_i    = wdata_a[g];
        assign busy_a[g]      = bus.busy_o;
        assign ack_a[g]       = bus.ack_o;
        assign err_a[g]       = bus.err_o;
        assign rdata_a[g]     = bus.rdata_o;
        data_mem_hs #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(lat_of(g))) dut (
            .clk_i(clk),
            .rst_i(rst),
            .bus  (bus)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    // Reference: byte-addressed memory, natural alignment, sign extension by arithmetic.
    function automatic logic [32:0] ref_access(input int d, input bit we, input logic [1:0] sz,
                                               input bit uns, input logic [31:0] a,
                                               input logic [31:0] wd);
        int unsigned n;
        logic [31:0] v;
        if (sz == 2'b11) return {1'b1, 32'h0};
        n = 1 << sz;
        if (a >= 4*DEPTH || (a % n) != 0) return {1'b1, 32'h0};
        if (we) begin
            for (int unsigned i = 0; i < n; i++) ref_mem[d][a+i] = wd[8*i +: 8];
            return 33'h0;
        end
        v = '0;
        for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = ref_mem[d][a+i];
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return {1'b0, v};
    endfunction

    task automatic drive(input int d, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_a[d]   = 1'b1;
        we_a[d]    = we;
        size_a[d]  = sz;
        uns_a[d]   = uns;
        addr_a[d]  = a;
        wdata_a[d] = wd;
    endtask

    task automatic push_exp(input int d, input bit we, input logic [1:0] sz, input bit uns,
                            input logic [31:0] a, input logic [31:0] wd);
        logic [32:0] r;
        exp_t e;
        r = ref_access(d, we, sz, uns, a, wd);
        e.d = d;
        e.rdata = r[31:0];
        e.err = r[32];
        exp_q.push_back(e);
    endtask

    task automatic issue(input int d, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        int ack_k;
        bit busy_ok;
        @(negedge clk);
        drive(d, we, sz, uns, a, wd);
        @(posedge clk);
        push_exp(d, we, sz, uns, a, wd);
        @(negedge clk);
        req_a[d] = 1'b0;
        ack_k = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= int'(lat_of(d)) + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (ack_a[d] === 1'b1 && ack_k == 0) ack_k = k;
            if (busy_a[d] !== (k <= int'(lat_of(d)))) busy_ok = 1'b0;
        end
        chk($sformatf("ack_cycle[d%0d]", d), ack_k, lat_of(d));
        chk($sformatf("busy_window[d%0d]", d), 32'(busy_ok), 32'd1);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ack_a[d] === 1'b1) begin
                chk($sformatf("ack_expected[d%0d]", d),
                    32'(exp_q.size() != 0 && exp_q[0].d == d), 32'd1);
                if (exp_q.size() != 0 && exp_q[0].d == d) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("rdata[d%0d]", d), rdata_a[d], e.rdata);
                    chk($sformatf("err[d%0d]", d), 32'(err_a[d]), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] ack_pat;
        bit seen;
        req_a = '0; we_a = '0; uns_a = '0;
        for (int d = 0; d < 3; d++) begin
            size_a[d] = '0; addr_a[d] = '0; wdata_a[d] = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_busy[d%0d]", d), 32'(busy_a[d]), 32'd0);
            chk($sformatf("rst_ack[d%0d]", d), 32'(ack_a[d]), 32'd0);
            chk($sformatf("rst_rdata[d%0d]", d), rdata_a[d], 32'd0);
            chk($sformatf("rst_err[d%0d]", d), 32'(err_a[d]), 32'd0);
        end
        rst = 1'b0;

        // Latency 2: word round trip, byte merge, sign/zero extension, faults.
        issue(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF);
        issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0);
        chk("plan_deadbeef", rdata_a[0], 32'hDEADBEEF);
        issue(0, 1, SZ_WORD, 0, 32'h10, 32'h0);
        issue(0, 1, SZ_BYTE, 0, 32'h11, 32'h7F);
        issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0);
        chk("plan_byte_merge", rdata_a[0], 32'h00007F00);
        issue(0, 1, SZ_BYTE, 0, 32'h12, 32'h80);
        issue(0, 0, SZ_BYTE, 0, 32'h12, 32'h0);
        chk("plan_byte_signed", rdata_a[0], 32'hFFFFFF80);
        issue(0, 0, SZ_BYTE, 1, 32'h12, 32'h0);
        chk("plan_byte_unsigned", rdata_a[0], 32'h00000080);
        issue(0, 1, SZ_HALF, 0, 32'h13, 32'h1234);
        chk("plan_half_misalign_err", 32'(err_a[0]), 32'd1);
        issue(0, 0, SZ_WORD, 0, 32'h22, 32'h0);
        issue(0, 0, SZ_WORD, 0, 4*DEPTH, 32'h0);
        chk("plan_oob_err", 32'(err_a[0]), 32'd1);
        issue(0, 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF);
        issue(0, 0, SZ_WORD, 0, 32'h10, 32'h0);
        chk("plan_unchanged", rdata_a[0], 32'h00807F00);

        // Latency 2: randomized traffic over a prefilled window.
        for (int unsigned w = 0; w < 16; w++) issue(0, 1, SZ_WORD, 0, 4*w, $urandom);
        for (int i = 0; i < 80; i++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r == 0)      a = 4*DEPTH + $urandom_range(0, 15);
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else             a = $urandom_range(0, 63);
            issue(0, bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)), a, $urandom);
        end

        // Latency 4: reset in the middle of a store aborts it.
        issue(1, 1, SZ_WORD, 0, 32'h20, 32'h11223344);
        @(negedge clk);
        drive(1, 1, SZ_WORD, 0, 32'h20, 32'hAAAAAAAA);
        @(posedge clk);
        @(negedge clk);
        req_a[1] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack_a[1] === 1'b1) seen = 1'b1;
        end
        chk("abort_no_ack", 32'(seen), 32'd0);
        issue(1, 0, SZ_WORD, 0, 32'h20, 32'h0);
        chk("abort_old_value", rdata_a[1], 32'h11223344);
        issue(1, 0, SZ_HALF, 0, 32'h22, 32'h0);

        // Latency 1: requests held high are accepted every other cycle.
        issue(2, 1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D);
        issue(2, 1, SZ_HALF, 0, 32'h42, 32'h8001);
        @(negedge clk);
        drive(2, 0, SZ_HALF, 0, 32'h42, 32'h0);
        @(posedge clk);
        repeat (3) push_exp(2, 0, SZ_HALF, 0, 32'h42, 32'h0);
        ack_pat = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            ack_pat[k-1] = ack_a[2];
            if (k == 6) req_a[2] = 1'b0;
        end
        chk("b2b_ack_pattern", 32'(ack_pat), 32'b010101);
        issue(2, 0, SZ_WORD, 0, 32'h40, 32'h0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_hs.md
# data_mem_hs

Parametrised, handshaked data memory for the processor's MEM stage. It generalises the single-cycle word memory in three ways: it has a configurable depth and access latency, it supports byte/halfword/word accesses with sign or zero extension, and it reports misaligned and out-of-range accesses. Requests use a req/busy/ack handshake, so the pipeline stalls on `busy_o` instead of assuming fixed one-cycle timing.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 4.
- `ADDR_W`, 32: byte-address width.
- `LATENCY`, 2: cycles from accept to `ack_o`; must be ≥ 1.

- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous and active-high.
- `req_i` input 1: access request; sampled only while `busy_o` = 0.
- `we_i` input 1: 1 = store, 0 = load.
- `size_i` input 2: access size; 00 byte, 01 half, 10 word, 11 reserved.
- `unsigned_i` input 1: load extension; 1 = zero-extend, 0 = sign-extend.
- `addr_i` input ADDR_W: byte address, little-endian.
- `wdata_i` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `busy_o` output 1: access in flight; new requests are ignored.
- `ack_o` output 1: one-cycle completion pulse.
- `rdata_o` output 32: extended load data; valid when `ack_o` = 1.
- `err_o` output 1: access fault; valid when `ack_o` = 1.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_i` = 1 latches `we_i`, `size_i`, `unsigned_i`, `addr_i` and `wdata_i`.
  - Goes to RESP if `LATENCY` = 1; otherwise goes to WAIT with cnt = `LATENCY`−2.
- **WAIT**: decrement cnt; at cnt = 0 go to RESP.
- **RESP**: `ack_o` = 1 for exactly one cycle, then return to IDLE.
- `busy_o` = (state ≠ IDLE).
- Word index = addr[log2(DEPTH)+1:2]; byte lane = addr[1:0].
- Fault conditions:
  - addr ≥ 4·DEPTH;
  - half access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0;
  - `size_i` = 11.
- On a fault: no array write, `rdata_o` = 0, `err_o` = 1.
- Stores:
  - The memory array and the read sample both update on the edge that enters RESP.
  - Only the addressed lanes are written: byte → lane addr[1:0]; half → lanes {addr[1], 0}..+1; word → all four.
- Loads:
  - Extract the addressed lanes, then sign- or zero-extend to 32 bits.
  - A word load ignores `unsigned_i`.
- A store completes with `rdata_o` = 0 and `err_o` = 0 (or `err_o` = 1 on a fault).

## Timing
- Accept cycle T is an IDLE cycle with `req_i` = 1.
- `busy_o` = 1 for cycles T+1..T+`LATENCY`.
- `ack_o` = 1 in cycle T+`LATENCY`.
- The earliest next accept is T+`LATENCY`+1; maximum throughput is one access per `LATENCY`+1 cycles.
- `rdata_o` and `err_o` hold their values after the ack until the next ack.
- Read-after-write: a load accepted after a store's ack returns the new data.
- Reset values: state IDLE, `busy_o` 0, `ack_o` 0, `rdata_o` 0, `err_o` 0, cnt 0.
- The memory array is not reset; its contents are retained across `rst_i`.
- Reset during WAIT, or before the RESP-entry edge, aborts the access: no write occurs and no ack is issued.
- Reset asserted in the RESP cycle: the write has already committed; `ack_o` drops immediately.
- `req_i` while `busy_o` = 1 is dropped silently; the requester must hold `req_i` until it sees `busy_o` = 0 on an accept edge.

## Structure
- Package `dmem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state enum;
  - function computing the counter width as $clog2(`LATENCY`).
- Sub-module `dmem_lane_align`, purely combinational:
  - takes size, addr[1:0], unsigned, the old word and the store data;
  - produces the merged store word and the extended load value.
- Top level holds the FSM, latency counter, request latch, fault decode and the `DEPTH`×32 array.

## Test plan
- `LATENCY`=2, store word 0xDEADBEEF at addr 0x10 at T → `busy_o` = 1 at T+1..T+2, `ack_o` at T+2, `err_o` = 0; load word 0x10 → `rdata_o` = 0xDEADBEEF.
- Store byte 0x7F at 0x11 over word 0x00000000, then load word 0x10 → 0x00007F00.
- Store byte 0x80 at 0x12, then load byte 0x12 signed → 0xFFFFFF80; unsigned → 0x00000080.
- Half store at 0x13, word load at 0x22, and word load at 4·DEPTH → `err_o` = 1, `rdata_o` = 0, memory unchanged.
- `LATENCY`=4, store accepted at T, `rst_i` pulsed at T+2 → no `ack_o`; a later load of that address returns the old value.
- `LATENCY`=1, back-to-back requests held high → acks at T+1, T+3, T+5; the request in the busy cycle is ignored.
